control_sequencer: RTL and testbench

- Hardwired fetch/decode/execute controller for the ALUSystem datapath: register file, ALU, address register file, IR, memory and MuxA/B/C.
- Drives every ALUSystem control input and sits beside the datapath inside CompleteSystem.
- Each instruction takes 3 clocks: fetch low byte, fetch high byte, execute.

---
 rtl/control_sequencer.sv | 164 ++++++++++++++++
 tb/tb_control_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/decode/execute controller for the ALUSystem datapath
// Three clocks per instruction; control outputs are decoded from the state register and IROut.
module control_sequencer #(
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  ALUOutFlag,
  output logic [1:0]  RF_OutASel,
  output logic [1:0]  RF_OutBSel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Enable,
  output logic [1:0]  IR_Funsel,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic        halted,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_FETCH_L = 3'd1,
    S_FETCH_H = 3'd2,
    S_EXEC    = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t     r_state;
  logic       r_z;
  logic [3:0] w_op;
  logic [1:0] w_rd;
  logic [1:0] w_ra;
  logic [1:0] w_rb;
  logic [3:0] w_rd_en;
  logic       w_unused;

  assign w_op     = IROut[15:12];
  assign w_rd     = IROut[11:10];
  assign w_ra     = IROut[9:8];
  assign w_rb     = IROut[7:6];
  // Register code 00 selects R1, which sits in the MSB of the active-low enable
  assign w_rd_en  = ~(4'b1000 >> w_rd);
  assign w_unused = ^{IROut[5:0], ALUOutFlag[2:0]};
  assign state    = r_state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_INIT;
      r_z     <= 1'b0;
    end else begin
      case (r_state)
        S_INIT:    r_state <= S_FETCH_L;
        S_FETCH_L: r_state <= S_FETCH_H;
        S_FETCH_H: r_state <= S_EXEC;
        S_EXEC: begin
          if (w_op <= 4'h3) r_z <= ALUOutFlag[3];
          r_state <= (w_op == 4'hF) ? S_HALT : S_FETCH_L;
        end
        S_HALT:    r_state <= S_HALT;
        default:   r_state <= S_INIT;
      endcase
    end
  end

  always_comb begin
    RF_OutASel  = 2'b00;
    RF_OutBSel  = 2'b00;
    RF_FunSel   = 2'b00;
    RF_RegSel   = 4'b1111;
    ALU_FunSel  = 4'b0000;
    ARF_OutCSel = 2'b00;
    ARF_OutDSel = 2'b00;
    ARF_FunSel  = 2'b00;
    ARF_RegSel  = 3'b111;
    IR_LH       = 1'b0;
    IR_Enable   = 1'b0;
    IR_Funsel   = 2'b00;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 1'b0;
    halted      = 1'b0;
    case (r_state)
      S_INIT: begin
        if (INIT_CLEAR) begin
          RF_RegSel  = 4'b0000;
          RF_FunSel  = 2'b11;
          ARF_RegSel = 3'b000;
          ARF_FunSel = 2'b11;
        end
      end
      S_FETCH_L, S_FETCH_H: begin
        Mem_CS     = 1'b0;
        IR_Enable  = 1'b1;
        IR_LH      = (r_state == S_FETCH_H);
        IR_Funsel  = 2'b10;
        ARF_RegSel = 3'b011;
        ARF_FunSel = 2'b01;
      end
      S_EXEC: begin
        case (w_op)
          4'h0, 4'h1, 4'h2, 4'h3: begin
            RF_OutASel = w_ra;
            RF_OutBSel = w_rb;
            case (w_op)
              4'h0:    ALU_FunSel = 4'b0100;
              4'h1:    ALU_FunSel = 4'b0101;
              4'h2:    ALU_FunSel = 4'b0111;
              default: ALU_FunSel = 4'b1000;
            endcase
            RF_FunSel = 2'b10;
            RF_RegSel = w_rd_en;
          end
          4'h4: begin
            MuxASel   = 2'b10;
            RF_FunSel = 2'b10;
            RF_RegSel = w_rd_en;
          end
          4'h5: begin
            Mem_CS      = 1'b0;
            ARF_OutDSel = 2'b10;
            MuxASel     = 2'b01;
            RF_FunSel   = 2'b10;
            RF_RegSel   = w_rd_en;
          end
          4'h6: begin
            MuxBSel    = 2'b10;
            ARF_FunSel = 2'b10;
            ARF_RegSel = 3'b101;
          end
          4'h7: begin
            RF_OutASel  = w_rd;
            ARF_OutDSel = 2'b10;
            Mem_CS      = 1'b0;
            Mem_WR      = 1'b1;
          end
          4'h8, 4'h9: begin
            if (w_op == 4'h8 || r_z) begin
              MuxBSel    = 2'b10;
              ARF_FunSel = 2'b10;
              ARF_RegSel = 3'b011;
            end
          end
          default: ;
        endcase
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer
// Random instruction streams checked against an instruction-level reference model.
module tb_control_sequencer;

  logic        clock;
  logic        reset;
  logic [15:0] IROut;
  logic [3:0]  ALUOutFlag;
  logic [1:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel, ALU_FunSel;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
  logic [2:0]  ARF_RegSel;
  logic        IR_LH, IR_Enable;
  logic [1:0]  IR_Funsel;
  logic        Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel, halted;
  logic [2:0]  state;

  control_sequencer #(.INIT_CLEAR(1'b1)) dut (
    .clock(clock), .reset(reset), .IROut(IROut), .ALUOutFlag(ALUOutFlag),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .ALU_FunSel(ALU_FunSel), .ARF_OutCSel(ARF_OutCSel),
    .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
    .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel), .Mem_WR(Mem_WR),
    .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
    .halted(halted), .state(state)
  );

  typedef struct packed {
    logic [1:0] a_sel, b_sel, rf_fun;
    logic [3:0] rf_reg, alu_fun;
    logic [1:0] c_sel, d_sel, arf_fun;
    logic [2:0] arf_reg;
    logic       ir_lh, ir_en;
    logic [1:0] ir_fun;
    logic       mem_wr, mem_cs;
    logic [1:0] mux_a, mux_b;
    logic       mux_c, halt;
    logic [2:0] st;
  } ctl_t;

  ctl_t act;
  assign act = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel,
                ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH, IR_Enable,
                IR_Funsel, Mem_WR, Mem_CS, MuxASel, MuxBSel, MuxCSel, halted, state};

  localparam logic [3:0] RD_EN [4]    = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  localparam logic [3:0] ALU_CODE [4] = '{4'b0100, 4'b0101, 4'b0111, 4'b1000};

  ctl_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          phase;
  int          halt_cnt;
  int          cyc;
  logic        z;
  logic [15:0] instr;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic ctl_t idle(input int st);
    ctl_t c;
    c        = '0;
    c.rf_reg = 4'hF;
    c.arf_reg = 3'h7;
    c.mem_cs = 1'b1;
    c.st     = 3'(st);
    return c;
  endfunction

  function automatic ctl_t model(input int ph, input logic [15:0] ir, input logic zf);
    ctl_t       c;
    logic [3:0] op;
    logic [1:0] rd, ra, rb;
    op = ir[15:12]; rd = ir[11:10]; ra = ir[9:8]; rb = ir[7:6];
    c = idle(ph);
    if (ph == 0) begin
      c.rf_reg = 4'b0000; c.rf_fun = 2'b11; c.arf_reg = 3'b000; c.arf_fun = 2'b11;
    end else if (ph == 1 || ph == 2) begin
      c.mem_cs = 1'b0; c.ir_en = 1'b1; c.ir_lh = (ph == 2); c.ir_fun = 2'b10;
      c.arf_reg = 3'b011; c.arf_fun = 2'b01;
    end else if (ph == 4) begin
      c.halt = 1'b1;
    end else if (op < 4'h4) begin
      c.a_sel = ra; c.b_sel = rb; c.alu_fun = ALU_CODE[op[1:0]];
      c.rf_fun = 2'b10; c.rf_reg = RD_EN[rd];
    end else if (op == 4'h4) begin
      c.mux_a = 2'b10; c.rf_fun = 2'b10; c.rf_reg = RD_EN[rd];
    end else if (op == 4'h5) begin
      c.mem_cs = 1'b0; c.d_sel = 2'b10; c.mux_a = 2'b01; c.rf_fun = 2'b10; c.rf_reg = RD_EN[rd];
    end else if (op == 4'h6) begin
      c.mux_b = 2'b10; c.arf_fun = 2'b10; c.arf_reg = 3'b101;
    end else if (op == 4'h7) begin
      c.a_sel = rd; c.d_sel = 2'b10; c.mem_cs = 1'b0; c.mem_wr = 1'b1;
    end else if (op == 4'h8 || (op == 4'h9 && zf)) begin
      c.mux_b = 2'b10; c.arf_fun = 2'b10; c.arf_reg = 3'b011;
    end
    return c;
  endfunction

  // One clock of stimulus: drive inputs, queue the expected vector, advance the model
  task automatic step(input bit rst);
    int nxt;
    @(posedge clock);
    #1;
    if (rst) begin
      reset = 1'b0; phase = 0; z = 1'b0;
    end else begin
      reset = 1'b1;
    end
    IROut      = (phase == 3) ? instr : 16'($urandom);
    ALUOutFlag = 4'($urandom);
    sb.push_back(model(phase, IROut, z));
    if (rst) begin
      nxt = 0; halt_cnt = 0;
    end else begin
      case (phase)
        0: nxt = 1;
        1: nxt = 2;
        2: nxt = 3;
        3: nxt = (instr[15:12] == 4'hF) ? 4 : 1;
        default: nxt = 4;
      endcase
      if (phase == 3 && instr[15:12] <= 4'h3) z = ALUOutFlag[3];
      halt_cnt = (phase == 4) ? halt_cnt + 1 : 0;
    end
    if (nxt == 1) instr = 16'($urandom);
    phase = nxt;
  endtask

  task automatic mid_reset();
    @(posedge clock);
    #1;
    IROut = 16'($urandom);
    ALUOutFlag = 4'($urandom);
    #1;
    n_checks++;
    if (state !== 3'd2) begin
      n_fail++; $display("FAIL pre_reset_state got %0d expected 2", state);
    end
    #1;
    reset = 1'b0;
    sb.push_back(model(0, IROut, 1'b0));
    #1;
    n_checks++;
    if (state !== 3'd0 || IR_Enable !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got state=%0d ir_en=%b expected 0/0", state, IR_Enable);
    end
    phase = 0; z = 1'b0; halt_cnt = 0;
  endtask

  always @(negedge clock) begin
    if (sb.size() != 0) begin
      ctl_t e;
      e = sb.pop_front();
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL ctl_vector t=%0t got %h expected %h", $time, act, e);
      end
    end
  end

  initial begin
    bit mid_done;
    mid_done   = 1'b0;
    reset      = 1'b0;
    IROut      = 16'h0;
    ALUOutFlag = 4'h0;
    phase      = 0;
    halt_cnt   = 0;
    z          = 1'b0;
    instr      = 16'h0;
    #2;
    n_checks++;
    if (state !== 3'd0 || RF_RegSel !== 4'b0000) begin
      n_fail++; $display("FAIL reset_state got state=%0d regsel=%b expected 0/0000", state, RF_RegSel);
    end
    step(1'b1);
    step(1'b1);
    for (cyc = 0; cyc < 2000; cyc++) begin
      if (phase == 4 && halt_cnt >= 12) begin
        step(1'b1);
        step(1'b1);
      end else if (!mid_done && cyc > 900 && phase == 2) begin
        mid_reset();
        mid_done = 1'b1;
      end else begin
        step(1'b0);
      end
    end
    @(posedge clock);
    @(posedge clock);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain got %0d entries expected 0", sb.size());
    end
    n_checks++;
    if (!mid_done) begin
      n_fail++; $display("FAIL mid_reset_coverage got 0 expected 1");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
